dpram_arbiter: RTL and testbench
================================

# dpram_arbiter

Two-master arbiter and sequencer for the 16x16 dual-port RAM. It splits each master's request stream onto the RAM's write port and read port and arbitrates each port independently by round-robin, so one master's write and the other master's read can issue in the same cycle. All RAM-side controls are registered, and read data returns to the owning master with a fixed 2-cycle latency. The block also catches the one write that the RAM cannot perform, a 32-bit write at address 15.

## Interface
Parameters:
- AW, 4, RAM address width (fixed: 16 entries).
- DW, 16, RAM word width; write data is 2*DW.

Ports (i = 0, 1 for each master):
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- m{i}_req  in  1  request valid; held until granted.
- m{i}_we  in  1  1 = write, 0 = read.
- m{i}_addr  in  AW  word address.
- m{i}_wdata  in  2*DW  write data; [15:0] low half, [31:16] high half.
- m{i}_wstrb  in  2  write strobe (11 = both halves, 10 = high half only, 01 = low half only, 00 = none).
- m{i}_gnt  out  1  combinational grant; req&gnt = request accepted this cycle.
- m{i}_rvalid  out  1  read data valid pulse.
- m{i}_rdata  out  DW  read data, qualified by m{i}_rvalid.
- m{i}_err  out  1  1-cycle pulse: the accepted write was truncated.
- ram_wr_en, ram_wr_strb[1:0], ram_waddr[AW-1:0], ram_wdata[2*DW-1:0]  out  RAM write port.
- ram_rd_en, ram_raddr[AW-1:0]  out  RAM read port.
- ram_rdata  in  DW  RAM read data, registered inside the RAM 1 cycle after ram_rd_en.

## Operation
**Request classes**
- A write request is req&we; a read request is req&!we.
- The write port and read port each have their own round-robin pointer, wr_pri and rd_pri.

**Arbitration, per port, each cycle**
- If only one master requests the port, that master is granted.
- If both request, the master named by the port's pointer is granted.
- After any grant on a port, that port's pointer moves to the other master.
- If there is no grant, the pointer holds.
- A master is granted on at most one port per cycle, since it has a single request.

**Issue (registered, cycle after acceptance)**
- ram_wr_en = 1, carrying the winner's addr, wdata and wstrb.
- ram_rd_en = 1 with the winner's addr.
- Both are otherwise 0.
- An unused port's address, data and strobe regs hold their last value.

**Read return**
- A 2-stage owner/valid pipeline tracks which master owns each read.
- m{i}_rvalid pulses 2 cycles after acceptance.
- m{i}_rdata = ram_rdata when the owner is i; it holds its last value otherwise.

**Write rules**
- wstrb=11 at addr 15: the RAM cannot write addr+1. The arbiter issues it as wstrb=01 (low half to address 15 only) and pulses m{i}_err in the issue cycle.
- wstrb=11 at addr 0..14: the RAM writes addr and addr+1.
- wstrb=00: the request is granted and consumed, ram_wr_en stays 0, and there is no error.

**Reset**
- Asynchronous, clears all registers.
- Every output is 0, including ram_* controls, addresses, data, rdata, rvalid and err.
- wr_pri = rd_pri = M0.
- Reads in flight are dropped with no rvalid.

## Timing
- Cycle N: req is sampled and gnt is asserted combinationally in N.
- Cycle N+1: the RAM controls are driven and the RAM updates or samples at the end of N+1.
- Cycle N+2: rvalid and rdata are presented to the master.
- Throughput: one read plus one write per cycle in total; back-to-back grants to the same master are allowed if the other master is idle.
- Same-cycle write (accepted N) and read (accepted N) to the same address: the read returns the OLD data.
- Read accepted at N+1 after a write accepted at N: the read returns the NEW data.
- Reset asserted mid-operation: outputs clear immediately. After release, the first grant can occur in the first cycle rst_n is high at a clk edge.

## Test plan
- **Reset:** hold rst_n=0 with both req high.
  - All outputs read 0 and no gnt is given.
  - After release, with both masters requesting writes, M0 is granted first, then M1 alternates.
- **Concurrent ports:** in one cycle, M0 writes addr 3 with wstrb=11 and wdata=0xBEEF_1234, while M1 reads addr 3.
  - Both are granted; M1 gets rdata=0x0000 at N+2.
  - A following M1 read of addr 3 returns 0x1234; a read of addr 4 returns 0xBEEF.
- **Round-robin fairness:** both masters issue continuous reads of addr 5 for 6 cycles.
  - Grants alternate M0, M1, M0, ...
  - Each rvalid goes to the correct master, 2 cycles after its own grant.
- **Boundary write:** M1 writes addr 15, wstrb=11, wdata=0xAAAA_5555.
  - ram_wr_strb=01 and m1_err pulses once.
  - Address 15 reads 0x5555 and address 0 is unchanged.
- **Strobes:** wstrb=10 to addr 7 with 0x1111_2222 gives mem[7]=0x1111.
  - wstrb=00 is granted, ram_wr_en stays 0 and memory is unchanged.
- **Reset mid-read:** assert rst_n=0 in the cycle after a read grant.
  - No rvalid is produced after release.
  - rd_pri restarts at M0.

Source files
------------

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: two-master round-robin arbiter and sequencer for a 16x16 dual-port RAM.
// Write and read ports arbitrate independently; read data returns to its owner two cycles after grant.
module dpram_arbiter #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [AW-1:0]     m0_addr,
    input  logic [2*DW-1:0]   m0_wdata,
    input  logic [1:0]        m0_wstrb,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DW-1:0]     m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [AW-1:0]     m1_addr,
    input  logic [2*DW-1:0]   m1_wdata,
    input  logic [1:0]        m1_wstrb,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DW-1:0]     m1_rdata,
    output logic              m1_err,
    output logic              ram_wr_en,
    output logic [1:0]        ram_wr_strb,
    output logic [AW-1:0]     ram_waddr,
    output logic [2*DW-1:0]   ram_wdata,
    output logic              ram_rd_en,
    output logic [AW-1:0]     ram_raddr,
    input  logic [DW-1:0]     ram_rdata
);
    logic [1:0]             req;
    logic [1:0]             we;
    logic [1:0][AW-1:0]     addr;
    logic [1:0][2*DW-1:0]   wdata;
    logic [1:0][1:0]        wstrb;
    logic [1:0]             wr_req;
    logic [1:0]             rd_req;
    logic [1:0]             wr_gnt;
    logic [1:0]             rd_gnt;
    logic                   wr_pri_reg;
    logic                   rd_pri_reg;

    assign req   = {m1_req, m0_req};
    assign we    = {m1_we, m0_we};
    assign addr  = {m1_addr, m0_addr};
    assign wdata = {m1_wdata, m0_wdata};
    assign wstrb = {m1_wstrb, m0_wstrb};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_class
            assign wr_req[gi] = req[gi] & we[gi];
            assign rd_req[gi] = req[gi] & ~we[gi];
        end
    endgenerate

    // Pointer value names the master favoured on a tie (0 = M0). No grants while in reset.
    assign wr_gnt[0] = rst_n & wr_req[0] & (~wr_req[1] | ~wr_pri_reg);
    assign wr_gnt[1] = rst_n & wr_req[1] & (~wr_req[0] |  wr_pri_reg);
    assign rd_gnt[0] = rst_n & rd_req[0] & (~rd_req[1] | ~rd_pri_reg);
    assign rd_gnt[1] = rst_n & rd_req[1] & (~rd_req[0] |  rd_pri_reg);

    assign m0_gnt = wr_gnt[0] | rd_gnt[0];
    assign m1_gnt = wr_gnt[1] | rd_gnt[1];

    logic              wr_sel;
    logic              rd_sel;
    logic              wr_any;
    logic              rd_any;
    logic [AW-1:0]     w_addr;
    logic [2*DW-1:0]   w_data;
    logic [1:0]        w_strb;
    logic [1:0]        w_strb_eff;
    logic              w_trunc;
    logic              wr_issue;

    assign wr_sel   = wr_gnt[1];
    assign rd_sel   = rd_gnt[1];
    assign wr_any   = |wr_gnt;
    assign rd_any   = |rd_gnt;
    assign w_addr   = addr[wr_sel];
    assign w_data   = wdata[wr_sel];
    assign w_strb   = wstrb[wr_sel];
    // A full-width write at the top address has no addr+1; keep only the low half.
    assign w_trunc    = wr_any && (w_strb == 2'b11) && (w_addr == {AW{1'b1}});
    assign w_strb_eff = w_trunc ? 2'b01 : w_strb;
    assign wr_issue   = wr_any && (w_strb != 2'b00);

    logic       s1_valid_reg;
    logic       s1_owner_reg;
    logic       s2_valid_reg;
    logic       s2_owner_reg;
    logic [1:0] err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pri_reg   <= 1'b0;
            rd_pri_reg   <= 1'b0;
            ram_wr_en    <= 1'b0;
            ram_wr_strb  <= 2'b00;
            ram_waddr    <= '0;
            ram_wdata    <= '0;
            ram_rd_en    <= 1'b0;
            ram_raddr    <= '0;
            err_reg      <= 2'b00;
            s1_valid_reg <= 1'b0;
            s1_owner_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_owner_reg <= 1'b0;
        end else begin
            if (wr_gnt[0])
                wr_pri_reg <= 1'b1;
            else if (wr_gnt[1])
                wr_pri_reg <= 1'b0;
            if (rd_gnt[0])
                rd_pri_reg <= 1'b1;
            else if (rd_gnt[1])
                rd_pri_reg <= 1'b0;

            ram_wr_en <= wr_issue;
            if (wr_issue) begin
                ram_waddr   <= w_addr;
                ram_wdata   <= w_data;
                ram_wr_strb <= w_strb_eff;
            end
            err_reg <= wr_gnt & {2{w_trunc}};

            ram_rd_en <= rd_any;
            if (rd_any)
                ram_raddr <= addr[rd_sel];

            s1_valid_reg <= rd_any;
            s1_owner_reg <= rd_sel;
            s2_valid_reg <= s1_valid_reg;
            s2_owner_reg <= s1_owner_reg;
        end
    end

    assign m0_err = err_reg[0];
    assign m1_err = err_reg[1];

    logic [1:0]          rvalid;
    logic [1:0][DW-1:0]  rdata;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            logic [DW-1:0] hold_reg;

            assign rvalid[gi] = s2_valid_reg && (s2_owner_reg == 1'(gi));
            // RAM output passes straight through in the return cycle, then is held.
            assign rdata[gi]  = rvalid[gi] ? ram_rdata : hold_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    hold_reg <= '0;
                else if (rvalid[gi])
                    hold_reg <= ram_rdata;
            end
        end
    endgenerate

    assign m0_rvalid = rvalid[0];
    assign m1_rvalid = rvalid[1];
    assign m0_rdata  = rdata[0];
    assign m1_rdata  = rdata[1];

endmodule

// File: tb/tb_dpram_arbiter.sv
// Testbench for dpram_arbiter: behavioural read-first RAM plus a read-return scoreboard
// fed from a shadow memory updated at every accepted request.
module tb_dpram_arbiter;
    localparam int AW = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0]   m0_addr = '0;
    logic [2*DW-1:0] m0_wdata = '0;
    logic [1:0]      m0_wstrb = '0;
    logic            m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0]   m1_addr = '0;
    logic [2*DW-1:0] m1_wdata = '0;
    logic [1:0]      m1_wstrb = '0;
    logic            m0_gnt, m0_rvalid, m0_err;
    logic            m1_gnt, m1_rvalid, m1_err;
    logic [DW-1:0]   m0_rdata, m1_rdata;
    logic            ram_wr_en, ram_rd_en;
    logic [1:0]      ram_wr_strb;
    logic [AW-1:0]   ram_waddr, ram_raddr;
    logic [2*DW-1:0] ram_wdata;
    logic [DW-1:0]   ram_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] shadow [16];

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    dpram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_wr_en(ram_wr_en), .ram_wr_strb(ram_wr_strb), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_rd_en(ram_rd_en), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-first RAM; a full write at the top address wraps, so a missed truncation corrupts address 0.
    always @(posedge clk) begin
        logic [3:0] nxt;
        nxt = ram_waddr + 4'd1;
        if (ram_rd_en) ram_rdata <= mem[ram_raddr];
        if (ram_wr_en) begin
            case (ram_wr_strb)
                2'b11: begin mem[ram_waddr] <= ram_wdata[15:0]; mem[nxt] <= ram_wdata[31:16]; end
                2'b01: mem[ram_waddr] <= ram_wdata[15:0];
                2'b10: mem[ram_waddr] <= ram_wdata[31:16];
                default: ;
            endcase
        end
    end

    function automatic void shadow_write(input logic [3:0] a, input logic [31:0] d, input logic [1:0] s);
        case (s)
            2'b11: begin
                shadow[a] = d[15:0];
                if (a != 4'hF) shadow[a + 4'd1] = d[31:16];
            end
            2'b01: shadow[a] = d[15:0];
            2'b10: shadow[a] = d[31:16];
            default: ;
        endcase
    endfunction

    // Scoreboard: check returns first, then log this cycle's grants (reads see pre-write data).
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (m0_rvalid) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL m0_unexpected_rvalid: got rdata=%h at cycle %0d, required no return", m0_rdata, cyc);
                end else begin
                    e = q0.pop_front();
                    if (m0_rdata !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL m0_read_return: got %h at cycle %0d, required %h at cycle %0d", m0_rdata, cyc, e.data, e.due);
                    end else
                        $display("m0 read return %h at cycle %0d", m0_rdata, cyc);
                end
            end else if (q0.size() != 0 && q0[0].due <= cyc) begin
                checks++;
                errors++;
                e = q0.pop_front();
                $display("FAIL m0_missing_rvalid: got no rvalid at cycle %0d, required %h", cyc, e.data);
            end
            if (m1_rvalid) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL m1_unexpected_rvalid: got rdata=%h at cycle %0d, required no return", m1_rdata, cyc);
                end else begin
                    e = q1.pop_front();
                    if (m1_rdata !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL m1_read_return: got %h at cycle %0d, required %h at cycle %0d", m1_rdata, cyc, e.data, e.due);
                    end else
                        $display("m1 read return %h at cycle %0d", m1_rdata, cyc);
                end
            end else if (q1.size() != 0 && q1[0].due <= cyc) begin
                checks++;
                errors++;
                e = q1.pop_front();
                $display("FAIL m1_missing_rvalid: got no rvalid at cycle %0d, required %h", cyc, e.data);
            end
            if (m0_gnt && !m0_we) q0.push_back('{data: shadow[m0_addr], due: cyc + 2});
            if (m1_gnt && !m1_we) q1.push_back('{data: shadow[m1_addr], due: cyc + 2});
            if (m0_gnt && m0_we) shadow_write(m0_addr, m0_wdata, m0_wstrb);
            if (m1_gnt && m1_we) shadow_write(m1_addr, m1_wdata, m1_wstrb);
        end
    end

    task automatic set_m0(input logic req, input logic we, input logic [3:0] a, input logic [31:0] d, input logic [1:0] s);
        m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [3:0] a, input logic [31:0] d, input logic [1:0] s);
        m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    endtask

    task automatic idle();
        set_m0(1'b0, 1'b0, 4'd0, 32'd0, 2'b00);
        set_m1(1'b0, 1'b0, 4'd0, 32'd0, 2'b00);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [81:0] outs;
        #2 rst_n = 1'b0;
        set_m0(1'b1, 1'b1, 4'd8, 32'h0000_0808, 2'b01);
        set_m1(1'b1, 1'b1, 4'd9, 32'h0000_0909, 2'b01);
        repeat (3) begin
            @(negedge clk);
            outs = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, m0_rdata, m1_rdata,
                    ram_wr_en, ram_wr_strb, ram_waddr, ram_wdata, ram_rd_en, ram_raddr};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %h, required all zero", outs);
            end
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL reset_first_grant[%0d]: got gnt=%b, required %b", k, {m0_gnt, m1_gnt},
                         (k % 2 == 0) ? 2'b10 : 2'b01);
            end
            step();
        end
        idle();
        repeat (3) step();
    endtask

    task automatic test_concurrent();
        set_m0(1'b1, 1'b1, 4'd3, 32'hBEEF_1234, 2'b11);
        set_m1(1'b1, 1'b0, 4'd3, 32'd0, 2'b00);
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b11) begin
            errors++;
            $display("FAIL concurrent_gnt: got %b, required 11", {m0_gnt, m1_gnt});
        end
        step();
        set_m0(1'b0, 1'b0, 4'd0, 32'd0, 2'b00);
        @(negedge clk);
        checks++;
        if ({ram_wr_en, ram_wr_strb, ram_waddr, ram_wdata, ram_rd_en, ram_raddr} !==
            {1'b1, 2'b11, 4'd3, 32'hBEEF_1234, 1'b1, 4'd3}) begin
            errors++;
            $display("FAIL concurrent_issue: got we=%b strb=%b wa=%h wd=%h re=%b ra=%h, required 1 11 3 beef1234 1 3",
                     ram_wr_en, ram_wr_strb, ram_waddr, ram_wdata, ram_rd_en, ram_raddr);
        end
        step();
        set_m1(1'b1, 1'b0, 4'd4, 32'd0, 2'b00);
        @(negedge clk);
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL concurrent_old_data: got rvalid=%b rdata=%h, required 1 0000", m1_rvalid, m1_rdata);
        end
        step();
        idle();
        @(negedge clk);
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL concurrent_new_low: got rvalid=%b rdata=%h, required 1 1234", m1_rvalid, m1_rdata);
        end
        step();
        @(negedge clk);
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL concurrent_new_high: got rvalid=%b rdata=%h, required 1 beef", m1_rvalid, m1_rdata);
        end
        repeat (3) step();
    endtask

    task automatic test_fairness();
        set_m0(1'b1, 1'b0, 4'd5, 32'd0, 2'b00);
        set_m1(1'b1, 1'b0, 4'd5, 32'd0, 2'b00);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL fairness_gnt[%0d]: got %b, required %b", k, {m0_gnt, m1_gnt},
                         (k % 2 == 0) ? 2'b10 : 2'b01);
            end
            step();
        end
        idle();
        repeat (4) step();
    endtask

    task automatic test_boundary();
        set_m1(1'b1, 1'b1, 4'hF, 32'hAAAA_5555, 2'b11);
        @(negedge clk);
        checks++;
        if (m1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL boundary_gnt: got %b, required 1", m1_gnt);
        end
        step();
        idle();
        @(negedge clk);
        checks++;
        if ({ram_wr_en, ram_wr_strb, ram_waddr, m1_err, m0_err} !== {1'b1, 2'b01, 4'hF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL boundary_issue: got we=%b strb=%b wa=%h m1_err=%b m0_err=%b, required 1 01 f 1 0",
                     ram_wr_en, ram_wr_strb, ram_waddr, m1_err, m0_err);
        end
        step();
        set_m0(1'b1, 1'b0, 4'hF, 32'd0, 2'b00);
        @(negedge clk);
        checks++;
        if (m1_err !== 1'b0) begin
            errors++;
            $display("FAIL boundary_err_pulse: got m1_err=%b one cycle later, required 0", m1_err);
        end
        step();
        set_m0(1'b1, 1'b0, 4'h0, 32'd0, 2'b00);
        @(negedge clk);
        step();
        idle();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 16'h5555) begin
            errors++;
            $display("FAIL boundary_addr15: got rvalid=%b rdata=%h, required 1 5555", m0_rvalid, m0_rdata);
        end
        step();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL boundary_addr0: got rvalid=%b rdata=%h, required 1 0000", m0_rvalid, m0_rdata);
        end
        repeat (3) step();
    endtask

    task automatic test_strobes();
        set_m0(1'b1, 1'b1, 4'd7, 32'h1111_2222, 2'b10);
        @(negedge clk);
        step();
        idle();
        @(negedge clk);
        checks++;
        if ({ram_wr_en, ram_wr_strb, ram_waddr} !== {1'b1, 2'b10, 4'd7}) begin
            errors++;
            $display("FAIL strobe_high_issue: got we=%b strb=%b wa=%h, required 1 10 7", ram_wr_en, ram_wr_strb, ram_waddr);
        end
        step();
        set_m0(1'b1, 1'b1, 4'd7, 32'hFFFF_FFFF, 2'b00);
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL strobe_none_gnt: got %b, required 1", m0_gnt);
        end
        step();
        idle();
        @(negedge clk);
        checks++;
        if (ram_wr_en !== 1'b0 || m0_err !== 1'b0) begin
            errors++;
            $display("FAIL strobe_none_issue: got we=%b err=%b, required 0 0", ram_wr_en, m0_err);
        end
        step();
        set_m0(1'b1, 1'b0, 4'd7, 32'd0, 2'b00);
        @(negedge clk);
        step();
        idle();
        @(negedge clk);
        step();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 16'h1111) begin
            errors++;
            $display("FAIL strobe_mem7: got rvalid=%b rdata=%h, required 1 1111", m0_rvalid, m0_rdata);
        end
        repeat (3) step();
    endtask

    task automatic test_reset_mid_read();
        set_m0(1'b1, 1'b0, 4'd3, 32'd0, 2'b00);
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midreset_gnt: got %b, required 1", m0_gnt);
        end
        step();
        rst_n = 1'b0;
        idle();
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
                errors++;
                $display("FAIL midreset_no_rvalid[%0d]: got %b, required 00", k, {m0_rvalid, m1_rvalid});
            end
            step();
        end
        set_m0(1'b1, 1'b0, 4'd2, 32'd0, 2'b00);
        set_m1(1'b1, 1'b0, 4'd2, 32'd0, 2'b00);
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_rd_pri: got %b, required 10", {m0_gnt, m1_gnt});
        end
        step();
        idle();
        repeat (5) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        foreach (mem[i]) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        test_reset();
        test_concurrent();
        test_fairness();
        test_boundary();
        test_strobes();
        test_reset_mid_read();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d reads outstanding, required 0/0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
